// File: rtl/fifo_serial_pkg.sv
// fifo_serial_pkg: definitions shared by the FIFO serial transmitter and its timer.
//   tx_state_e   : FSM state encoding
//   IdleLevel    : serial line level while nothing is being sent
//   StartBits    : number of start bits per frame
//   StopBits     : number of stop bits per frame
//   frame_cycles : clock cycles one frame occupies on the line
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic        IdleLevel = 1'b1;
    localparam int unsigned StartBits = 1;
    localparam int unsigned StopBits  = 1;

    function automatic int unsigned frame_cycles(input int unsigned width,
                                                 input int unsigned clkdiv,
                                                 input int unsigned parity_bits);
        return (StartBits + width + parity_bits + StopBits) * clkdiv;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer: free-running CLKDIV divider that marks the last cycle of each serial bit.
//   clk   : system clock
//   res_n : asynchronous active-low reset
//   clear : synchronous restart, counter is 0 in the following cycle
//   tick  : high during the last cycle (count == CLKDIV-1) of each bit period
module bit_timer #(
    parameter int unsigned CLKDIV = 16
) (
    input  logic clk,
    input  logic res_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKDIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a FIFO read port and sends each as an async serial frame
// (start bit, WIDTH data bits LSB first, optional even parity bit, stop bit).
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN inserts the parity bit.
//   clk       : system clock
//   res_n     : asynchronous active-low reset, aborts any frame in flight
//   enable    : permits starting a new frame (only looked at in idle)
//   empty     : FIFO empty flag
//   rdata     : FIFO read data, valid the cycle after the shift_out edge
//   shift_out : FIFO pop request, one cycle per frame
//   tx        : serial line, idle high, registered
//   busy      : high whenever a frame is in progress
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CLKDIV = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             shift_out,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic             timer_clear;
    logic             tick;

`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    bit_timer #(
        .CLKDIV(CLKDIV)
    ) u_bit_timer (
        .clk  (clk),
        .res_n(res_n),
        .clear(timer_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        timer_clear = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (enable && !empty) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StLoad;
            end
            StLoad: begin
                shreg_d     = rdata;
                bit_cnt_d   = '0;
                // Align bit periods with the start of the start bit.
                timer_clear = 1'b1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                parity_d    = ^rdata;
`endif
                state_d     = StStart;
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_d = IdleLevel;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = IdleLevel;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IdleLevel;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign shift_out = (state_q == StReq);
    assign busy      = (state_q != StIdle);
    assign tx        = tx_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: directed, table-driven bench for fifo_serial_tx (WIDTH=8, CLKDIV=4)
// with a small behavioural FIFO on its read port.
module tb_fifo_serial_tx;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CLKDIV = 4;
    localparam int          WaitMax =
        int'(fifo_serial_pkg::frame_cycles(WIDTH, CLKDIV, 1)) * 4;

    logic             clk = 1'b0;
    logic             res_n;
    logic             enable;
    logic             empty = 1'b1;
    logic [WIDTH-1:0] rdata = '0;
    logic             shift_out;
    logic             tx;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0;

    logic             push_valid = 1'b0;
    logic [WIDTH-1:0] push_data  = '0;
    logic [WIDTH-1:0] fifo_q[$];

    always #5 clk = ~clk;

    fifo_serial_tx #(
        .WIDTH (WIDTH),
        .CLKDIV(CLKDIV)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .enable   (enable),
        .empty    (empty),
        .rdata    (rdata),
        .shift_out(shift_out),
        .tx       (tx),
        .busy     (busy)
    );

    // FIFO model: registered read data, registered empty flag.
    always @(posedge clk) begin
        if (shift_out && fifo_q.size() > 0) rdata <= fifo_q.pop_front();
        if (push_valid) fifo_q.push_back(push_data);
        empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (shift_out === 1'b1) pop_cnt++;
    end

    typedef struct {
        logic [7:0] word;
        logic [9:0] exp;   // bit i = i-th bit on the line: start, d0..d7, stop
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        push_data  = w;
        push_valid = 1'b1;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    // Called just after a negedge. Waits for the pop, then checks every cycle of the frame.
    task automatic do_frame(input string name, input logic [9:0] exp10, input logic par,
                            input int drop_bit, input int rst_bit);
        logic [10:0] exp;
        int          nbits;
        int          t;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        exp   = {1'b1, par, exp10[8:0]};
        nbits = 11;
`else
        exp   = {1'b0, exp10};
        nbits = 10;
        if (par === 1'bx) exp = '0;
`endif
        t = 0;
        while (shift_out !== 1'b1 && t < WaitMax) begin
            @(negedge clk);
            t++;
        end
        if (shift_out !== 1'b1) begin
            chk({name, " pop timeout"}, 32'(shift_out), 32'd1);
            return;
        end
        @(negedge clk);
        chk({name, " pop pulse width"}, 32'(shift_out), 32'd0);
        chk({name, " load busy"}, 32'(busy), 32'd1);
        chk({name, " load tx"}, 32'(tx), 32'd1);
        @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < int'(CLKDIV); c++) begin
                if (b == drop_bit && c == 0) enable = 1'b0;
                if (b == rst_bit && c == 1) begin
                    res_n = 1'b0;
                    #1;
                    chk({name, " async reset tx"}, 32'(tx), 32'd1);
                    chk({name, " async reset busy"}, 32'(busy), 32'd0);
                    chk({name, " async reset shift_out"}, 32'(shift_out), 32'd0);
                    return;
                end
                chk($sformatf("%s bit%0d cyc%0d", name, b, c), 32'(tx), 32'(exp[b]));
                @(negedge clk);
            end
        end
        chk({name, " busy after stop"}, 32'(busy), 32'd0);
        chk({name, " tx after stop"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int p0;
        int bad;

        vecs[0] = '{word: 8'hA5, exp: 10'h34A, par: 1'b0};
        vecs[1] = '{word: 8'h01, exp: 10'h202, par: 1'b1};
        vecs[2] = '{word: 8'hFF, exp: 10'h3FE, par: 1'b0};
        vecs[3] = '{word: 8'h00, exp: 10'h200, par: 1'b0};
        vecs[4] = '{word: 8'h3C, exp: 10'h278, par: 1'b0};
        vecs[5] = '{word: 8'h5A, exp: 10'h2B4, par: 1'b0};
        vecs[6] = '{word: 8'h07, exp: 10'h20E, par: 1'b1};
        vecs[7] = '{word: 8'h03, exp: 10'h206, par: 1'b0};

        // Reset and idle with an empty FIFO.
        res_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("in reset tx", 32'(tx), 32'd1);
        chk("in reset busy", 32'(busy), 32'd0);
        chk("in reset shift_out", 32'(shift_out), 32'd0);
        res_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || shift_out !== 1'b0) bad++;
        end
        chk("idle 100 cycles bad cycles", 32'(bad), 32'd0);

        // Table: one word at a time.
        for (int i = 0; i < 8; i++) begin
            p0 = pop_cnt;
            push(vecs[i].word);
            do_frame($sformatf("vec%0d", i), vecs[i].exp, vecs[i].par, -1, -1);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d pop count", i), 32'(pop_cnt - p0), 32'd1);
        end

        // Back-to-back: one idle cycle between frames.
        enable = 1'b0;
        push(8'h01);
        push(8'hFF);
        p0 = pop_cnt;
        enable = 1'b1;
        do_frame("b2b first", 10'h202, 1'b1, -1, -1);
        @(negedge clk);
        chk("b2b second pop timing", 32'(shift_out), 32'd1);
        do_frame("b2b second", 10'h3FE, 1'b0, -1, -1);
        repeat (10) @(negedge clk);
        chk("b2b pop count", 32'(pop_cnt - p0), 32'd2);

        // Enable dropped mid-frame: frame finishes, nothing further popped.
        enable = 1'b0;
        push(8'h3C);
        push(8'h5A);
        push(8'hA5);
        p0 = pop_cnt;
        enable = 1'b1;
        do_frame("gate frame1", 10'h278, 1'b0, 3, -1);
        repeat (20) @(negedge clk);
        chk("gate pop count", 32'(pop_cnt - p0), 32'd1);
        chk("gate busy", 32'(busy), 32'd0);
        enable = 1'b1;
        do_frame("gate frame2", 10'h2B4, 1'b0, -1, -1);
        do_frame("gate frame3", 10'h34A, 1'b0, -1, -1);

        // Reset during data bit 3 (line bit 4); next queued word goes out intact.
        enable = 1'b0;
        push(8'h00);
        push(8'h3C);
        enable = 1'b1;
        do_frame("rst frame", 10'h200, 1'b0, -1, 4);
        @(negedge clk);
        chk("rst held busy", 32'(busy), 32'd0);
        res_n = 1'b1;
        do_frame("after rst", 10'h278, 1'b0, -1, -1);
        repeat (5) @(negedge clk);
        chk("final busy", 32'(busy), 32'd0);
        chk("final fifo empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
